aes_mix_columns_seq: RTL and testbench

Sequential forward MixColumns engine for the AES-256 encryption datapath. It is the encrypt-side counterpart of the decryption InvMixColumns helper. It accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per cycle through a single shared column unit. It returns the result over a second valid/ready handshake, between ShiftRows and AddRoundKey in the round pipeline. A `last_round` flag bypasses the transform for round 14.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_mix_column_unit.sv | 25 ++
 rtl/aes_mix_columns_seq.sv | 120 ++++++++++++
 tb/tb_aes_mix_columns_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: field constants, byte/column/state widths,
// GF(2^8) helpers and the MixColumns engine state encoding.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8); the shifted-out bit folds back in as AES_POLY.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by (x + 1) in GF(2^8).
  function automatic logic [BYTE_W-1:0] mul3(input logic [BYTE_W-1:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/aes_mix_column_unit.sv
// Combinational forward MixColumns for one 32-bit column.
// Byte [31:24] is row 0; the output keeps the same row ordering.
module aes_mix_column_unit
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a_s;
  logic [BYTE_W-1:0] b_s;
  logic [BYTE_W-1:0] c_s;
  logic [BYTE_W-1:0] d_s;

  assign {a_s, b_s, c_s, d_s} = col_in;

  // Circulant matrix {2,3,1,1} applied to the column.
  assign col_out = {
    xtime(a_s) ^ mul3(b_s)  ^ c_s        ^ d_s,
    a_s        ^ xtime(b_s) ^ mul3(c_s)  ^ d_s,
    a_s        ^ b_s        ^ xtime(c_s) ^ mul3(d_s),
    mul3(a_s)  ^ b_s        ^ c_s        ^ xtime(d_s)
  };

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential forward MixColumns: one column per cycle through a single
// shared column unit, valid/ready on both sides, bypass for the last round.
module aes_mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               last_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  mc_state_e          state_r;
  logic [1:0]         col_r;
  logic [STATE_W-1:0] work_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [COL_W-1:0]   cur_col_s;
  logic [COL_W-1:0]   mixed_col_s;

  // Replace column idx of a state with a new column value.
  function automatic logic [STATE_W-1:0] put_column(
    input logic [STATE_W-1:0] st,
    input logic [1:0]         idx,
    input logic [COL_W-1:0]   c
  );
    logic [STATE_W-1:0] r;
    r = st;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      2'd3:    r[31:0]   = c;
      default: r         = st;
    endcase
    return r;
  endfunction

  // Route the column currently being processed to the shared unit.
  always_comb begin
    cur_col_s = work_r[127:96];
    case (col_r)
      2'd0:    cur_col_s = work_r[127:96];
      2'd1:    cur_col_s = work_r[95:64];
      2'd2:    cur_col_s = work_r[63:32];
      2'd3:    cur_col_s = work_r[31:0];
      default: cur_col_s = work_r[127:96];
    endcase
  end

  aes_mix_column_unit u_col (
    .col_in  (cur_col_s),
    .col_out (mixed_col_s)
  );

  // Engine FSM with working register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      col_r       <= 2'd0;
      work_r      <= 128'h0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            work_r     <= in_state;
            col_r      <= 2'd0;
            in_ready_r <= 1'b0;
            if (last_round) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= ST_BUSY;
              out_valid_r <= 1'b0;
            end
          end else begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          work_r <= put_column(work_r, col_r, mixed_col_s);
          col_r  <= col_r + 2'd1;
          if (col_r == 2'd3) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            state_r     <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          col_r       <= 2'd0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = work_r;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: known-answer table, handshake corner cases
// and a randomized soak against a matrix-multiply reference model.
module tb_aes_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic [127:0] in_s;
    logic         last;
    logic [127:0] exp_s;
  } vec_t;

  vec_t tbl[8];

  aes_mix_columns_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // General GF(2^8) product by shift-and-add with reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // MixColumns as the circulant matrix product, or identity on the last round.
  function automatic logic [127:0] model(input logic [127:0] s, input logic last);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    if (last) return s;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], coef[(j - row + 4) % 4]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic wait_in_ready(input string nm);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk({nm, " in_ready timeout"}, 128'(in_ready), 128'd1);
  endtask

  // Apply one state, check latency and the result, then consume it.
  task automatic run_vec(input string nm, input logic [127:0] s, input logic last,
                         input logic [127:0] exp);
    int cyc;
    wait_in_ready(nm);
    in_valid   = 1'b1;
    in_state   = s;
    last_round = last;
    @(negedge clk);
    in_valid   = 1'b0;
    in_state   = {$urandom, $urandom, $urandom, $urandom};
    last_round = ~last;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 128'(cyc), last ? 128'd0 : 128'd4);
    chk({nm, " out_state"}, out_state, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " post-handshake valid/ready"}, {126'd0, out_valid, in_ready}, 128'b01);
  endtask

  logic [127:0] exp_q[$];
  int           n_got;
  bit           drv_done;

  initial begin
    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [127:0] s2;
    fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;

    tbl[0] = '{"fips_b_round1", fips_in, 1'b0, fips_out};
    tbl[1] = '{"col_db135345", {32'hdb135345, 96'h0}, 1'b0, {32'h8e4da1bc, 96'h0}};
    tbl[2] = '{"col_f20a225c", {32'hf20a225c, 96'h0}, 1'b0, {32'h9fdc589d, 96'h0}};
    tbl[3] = '{"col_01010101", {32'h01010101, 96'h0}, 1'b0, {32'h01010101, 96'h0}};
    tbl[4] = '{"col_c6c6c6c6", {32'hc6c6c6c6, 96'h0}, 1'b0, {32'hc6c6c6c6, 96'h0}};
    tbl[5] = '{"col_d4d4d4d5", {32'hd4d4d4d5, 96'h0}, 1'b0, {32'hd5d5d7d6, 96'h0}};
    tbl[6] = '{"col_2d26314c", {32'h2d26314c, 96'h0}, 1'b0, {32'h4d7ebdf8, 96'h0}};
    tbl[7] = '{"bypass", 128'h0123456789abcdeffedcba9876543210, 1'b1,
               128'h0123456789abcdeffedcba9876543210};

    rst_n = 1'b0; in_valid = 1'b0; in_state = 128'h0; last_round = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {out_state, in_ready, out_valid} , 130'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after release", 128'(in_ready), 128'd1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i].name, tbl[i].in_s, tbl[i].last, tbl[i].exp_s);

    // Backpressure: hold DONE for 10 cycles with a competing in_valid.
    wait_in_ready("bp");
    in_valid = 1'b1; in_state = fips_in; last_round = 1'b0;
    @(negedge clk);
    s2 = 128'h00112233445566778899aabbccddeeff;
    in_state = s2; last_round = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("bp hold", {out_state, out_valid, in_ready}, {fips_out, 1'b1, 1'b0});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", {126'd0, out_valid, in_ready}, 128'b01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp second accept", {126'd0, out_valid, in_ready}, 128'b10);
    chk("bp second result", out_state, s2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of BUSY, with col at 2.
    wait_in_ready("rst");
    in_valid = 1'b1; in_state = fips_in; last_round = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-busy reset", {out_state, in_ready, out_valid}, 130'h0);
    @(negedge clk);
    chk("reset held", {out_state, in_ready, out_valid}, 130'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("fips after reset", fips_in, 1'b0, fips_out);

    // Random soak with stalls on both sides.
    n_got = 0;
    drv_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 1000; t++) begin
          logic [127:0] rs;
          logic         rl;
          int           w;
          rs = {$urandom, $urandom, $urandom, $urandom};
          rl = 1'($urandom_range(0, 3) == 0);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          in_valid = 1'b1; in_state = rs; last_round = rl;
          w = 0;
          while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (in_ready !== 1'b1) begin
            chk("soak accept timeout", 128'(in_ready), 128'd1);
            break;
          end
          exp_q.push_back(model(rs, rl));
          @(negedge clk);
        end
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        int budget;
        budget = 0;
        while (n_got < 1000 && budget < 40000) begin
          @(negedge clk);
          budget++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              chk("soak unexpected result", out_state, 128'h0);
              n_got++;
            end else begin
              chk("soak result", out_state, exp_q.pop_front());
              n_got++;
            end
          end
        end
        out_ready = 1'b0;
      end
    join
    chk("soak result count", 128'(n_got), 128'd1000);
    chk("soak leftover", 128'(exp_q.size()), 128'd0);
    chk("soak driver finished", 128'(drv_done), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
